// File: rtl/rtc_reg_bank_alarm.sv
// RTC register bank: CPU-loaded / counter-tracking channels, readback and timer alarm FSM.
// Define REG_BANK_SNAPSHOT_EN to add a snap-loaded shadow bank driving ch_out.
module rtc_reg_bank_alarm #(
    parameter int N_CH    = 10,
    parameter int W       = 8,
    parameter int AW      = 4,
    parameter int TMR_SEC = 6,
    parameter int TMR_MIN = 7,
    parameter int TMR_HOR = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [N_CH-1:0]   src_cnt,
    input  logic [N_CH-1:0]   hold,
    input  logic [N_CH*W-1:0] count_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [W-1:0]      rd_data,
    output logic [N_CH*W-1:0] ch_out,
`ifdef REG_BANK_SNAPSHOT_EN
    input  logic              snap,
`endif
    input  logic              cfg_mode,
    input  logic              alarm_ack,
    output logic              alarm,
    output logic              show_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONF  = 2'd1,
        RUN   = 2'd2,
        ALARM = 2'd3
    } state_t;

    logic [W-1:0]      ch [N_CH];
    logic [N_CH*W-1:0] live_flat;
    logic [W-1:0]      rd_mux;
    logic [3*W-1:0]    tgt;
    logic [3*W-1:0]    cnt;
    logic              tgt_nz;
    logic              cnt_match;
    state_t            state;
    state_t            state_nx;

    // Addresses >= N_CH match no channel, so such writes fall through.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                ch[i] <= '0;
            else if (hold[i])
                ch[i] <= ch[i];
            else if (wr_en && wr_addr == AW'(i))
                ch[i] <= wr_data;
            else if (src_cnt[i])
                ch[i] <= count_data[i*W +: W];
        end
    end

    always_comb begin
        live_flat = '0;
        rd_mux    = '0;
        for (int i = 0; i < N_CH; i++) begin
            live_flat[i*W +: W] = ch[i];
            if (rd_addr == AW'(i))
                rd_mux = ch[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= rd_mux;
    end

`ifdef REG_BANK_SNAPSHOT_EN
    logic [N_CH*W-1:0] shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (snap)
            shadow <= live_flat;
    end

    assign ch_out = shadow;
`else
    assign ch_out = live_flat;
`endif

    // Target comes from the live bank; running value from the counters.
    assign tgt = {ch[TMR_HOR], ch[TMR_MIN], ch[TMR_SEC]};
    assign cnt = {count_data[TMR_HOR*W +: W],
                  count_data[TMR_MIN*W +: W],
                  count_data[TMR_SEC*W +: W]};
    assign tgt_nz    = |tgt;
    assign cnt_match = (cnt == tgt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cfg_mode)
                    state_nx = CONF;
            end
            CONF: begin
                if (!cfg_mode)
                    state_nx = tgt_nz ? RUN : IDLE;
            end
            RUN: begin
                if (cfg_mode)
                    state_nx = CONF;
                else if (cnt_match)
                    state_nx = ALARM;
            end
            ALARM: begin
                if (alarm_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alarm      = 1'b0;
        show_count = 1'b1;
        unique case (state)
            RUN:     show_count = 1'b0;
            ALARM:   alarm      = 1'b1;
            default: ;
        endcase
    end

endmodule
